// File: rtl/prbs19_checker.sv
// Purpose : PRBS19 receive checker; self-syncs on 19 bits, then compares the stream with a free-running reference LFSR.
// Latency : a bit accepted at edge n shows on locked/err_pulse/sync_lost/err_cnt at edge n+1; seed_seen lags R by one edge.
// Backpr. : none; the input is qualified by bit_vld only and every valid bit is consumed.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   bit_vld   bit_in qualifier; nothing advances while low
//   bit_in    received serial bit (generator Q_out[18])
//   clr_cnt   synchronous clear of err_cnt, wins over a same-cycle error
//   locked    checker is in CHECK state
//   err_pulse one-cycle pulse, last checked bit mismatched
//   err_cnt   running mismatch count
//   sync_lost one-cycle pulse on loss of lock
//   seed_seen one-cycle pulse, reference register equalled SEED on the previous edge
//
// Build option: define PRBS_ERR_SAT_EN to make err_cnt saturate at all-ones instead of wrapping.

module prbs19_checker #(
    parameter logic [18:0] SEED        = 19'b1110000010100000100,
    parameter int          ERR_CNT_W   = 16,
    parameter int          LOSS_WIN    = 64,
    parameter int          LOSS_THRESH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_vld,
    input  logic                 bit_in,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 sync_lost,
    output logic                 seed_seen
);

    localparam int WIN_W = $clog2(LOSS_WIN + 1);

    typedef enum logic {
        ST_ACQ   = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    state_t               r_state;
    logic [18:0]          r_ref;
    logic [4:0]           r_acq_cnt;
    logic [WIN_W-1:0]     r_win_bits;
    logic [WIN_W-1:0]     r_win_errs;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_err_pulse;
    logic                 r_sync_lost;
    logic                 r_seed_seen;

    state_t               w_state_nxt;
    logic [18:0]          w_ref_nxt;
    logic [4:0]           w_acq_nxt;
    logic [WIN_W-1:0]     w_win_bits_nxt;
    logic [WIN_W-1:0]     w_win_errs_nxt;
    logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
    logic                 w_err;
    logic                 w_loss;
    logic                 w_pred;
    logic [18:0]          w_ref_acq;
    logic [WIN_W-1:0]     w_win_bits_inc;
    logic [WIN_W-1:0]     w_win_errs_inc;

    // Same taps as the generator: the predicted bit is what the generator
    // shifts into Q[0], which reaches Q_out[18] nineteen shifts later.
    assign w_pred         = r_ref[4] ^ r_ref[13] ^ r_ref[17] ^ r_ref[18];
    assign w_ref_acq      = {r_ref[17:0], bit_in};
    assign w_win_bits_inc = r_win_bits + WIN_W'(1);
    assign w_win_errs_inc = r_win_errs + WIN_W'(w_err);

    always_comb begin
        w_state_nxt    = r_state;
        w_ref_nxt      = r_ref;
        w_acq_nxt      = r_acq_cnt;
        w_win_bits_nxt = r_win_bits;
        w_win_errs_nxt = r_win_errs;
        w_err          = 1'b0;
        w_loss         = 1'b0;

        if (bit_vld) begin
            case (r_state)
                ST_ACQ: begin
                    w_ref_nxt = w_ref_acq;
                    if (r_acq_cnt == 5'd18) begin
                        // An all-zero register would lock onto a dead LFSR.
                        w_acq_nxt = 5'd0;
                        if (w_ref_acq != 19'd0) begin
                            w_state_nxt = ST_CHECK;
                        end
                    end else begin
                        w_acq_nxt = r_acq_cnt + 5'd1;
                    end
                end
                ST_CHECK: begin
                    w_ref_nxt = {r_ref[17:0], w_pred};
                    w_err     = (bit_in != w_pred);
                    // Loss is tested first so it beats a coincident window end.
                    if (w_err && (w_win_errs_inc == WIN_W'(LOSS_THRESH))) begin
                        w_loss         = 1'b1;
                        w_state_nxt    = ST_ACQ;
                        w_ref_nxt      = 19'd0;
                        w_acq_nxt      = 5'd0;
                        w_win_bits_nxt = '0;
                        w_win_errs_nxt = '0;
                    end else if (w_win_bits_inc == WIN_W'(LOSS_WIN)) begin
                        w_win_bits_nxt = '0;
                        w_win_errs_nxt = '0;
                    end else begin
                        w_win_bits_nxt = w_win_bits_inc;
                        w_win_errs_nxt = w_win_errs_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACQ;
                end
            endcase
        end
    end

    // clr_cnt has priority; the erroring bit still pulses err_pulse.
    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if (clr_cnt) begin
            w_err_cnt_nxt = '0;
        end else if (w_err) begin
`ifdef PRBS_ERR_SAT_EN
            if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
                w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
            end
`else
            w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= ST_ACQ;
            r_ref       <= 19'd0;
            r_acq_cnt   <= 5'd0;
            r_win_bits  <= '0;
            r_win_errs  <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
            r_sync_lost <= 1'b0;
            r_seed_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ref       <= w_ref_nxt;
            r_acq_cnt   <= w_acq_nxt;
            r_win_bits  <= w_win_bits_nxt;
            r_win_errs  <= w_win_errs_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_err_pulse <= w_err;
            r_sync_lost <= w_loss;
            // Compares the current register every edge, whatever bit_vld is.
            r_seed_seen <= (r_ref == SEED);
        end
    end

    assign locked    = (r_state == ST_CHECK);
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign sync_lost = r_sync_lost;
    assign seed_seen = r_seed_seen;

endmodule

// File: tb/tb_prbs19_checker.sv
// Directed bench for prbs19_checker (ERR_CNT_W=4 so wrap/saturation is reachable).
// Stimulus is a reference PRBS19 generator started at SEED; errors are injected by inverting bits.
// Outputs are sampled 1 time unit after each rising edge.

module tb_prbs19_checker;

    localparam logic [18:0] SEED = 19'b1110000010100000100;

    logic       clk;
    logic       rst_n;
    logic       bit_vld;
    logic       bit_in;
    logic       clr_cnt;
    logic       locked;
    logic       err_pulse;
    logic [3:0] err_cnt;
    logic       sync_lost;
    logic       seed_seen;

    int total = 0;
    int bad   = 0;

    logic [18:0] g;
    logic        gb;
    int          n_err;
    int          n_lock;
    int          n_seed;
    int          n_lost;
    logic [31:0] exp_sat;

    prbs19_checker #(
        .SEED       (SEED),
        .ERR_CNT_W  (4),
        .LOSS_WIN   (64),
        .LOSS_THRESH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_vld  (bit_vld),
        .bit_in   (bit_in),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .sync_lost(sync_lost),
        .seed_seen(seed_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic vld, input logic b, input logic clr);
        bit_vld = vld;
        bit_in  = b;
        clr_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    // Generator output Q_out[18], then shift.
    task automatic gen_next(output logic b);
        b = g[18];
        g = {g[17:0], g[18] ^ g[17] ^ g[13] ^ g[4]};
    endtask

    initial begin
        // ---- 1. reset ----
        rst_n = 1'b1; bit_vld = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked",    32'(locked),    32'd0);
        check("rst_err_cnt",   32'(err_cnt),   32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_sync_lost", 32'(sync_lost), 32'd0);
        check("rst_seed_seen", 32'(seed_seen), 32'd0);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);

        // ---- 2. clean lock from SEED ----
        g = SEED;
        n_lock = 0;
        for (int i = 0; i < 18; i++) begin
            gen_next(gb); step(1'b1, gb, 1'b0);
            if (locked) n_lock++;
        end
        check("acq_no_early_lock", 32'(n_lock), 32'd0);
        gen_next(gb); step(1'b1, gb, 1'b0);
        check("lock_after_19", 32'(locked), 32'd1);
        check("seed_not_yet", 32'(seed_seen), 32'd0);
        gen_next(gb); step(1'b1, gb, 1'b0);
        check("seed_seen_pulse", 32'(seed_seen), 32'd1);
        check("first_check_ok", 32'(err_pulse), 32'd0);
        n_err = 0; n_seed = 0; n_lock = 0;
        for (int i = 0; i < 1983; i++) begin
            gen_next(gb); step(1'b1, gb, 1'b0);
            if (err_pulse) n_err++;
            if (seed_seen) n_seed++;
            if (!locked) n_lock++;
        end
        check("clean_err_pulses", 32'(n_err), 32'd0);
        check("clean_seed_once", 32'(n_seed), 32'd0);
        check("clean_unlocks", 32'(n_lock), 32'd0);
        check("clean_err_cnt", 32'(err_cnt), 32'd0);

        // ---- 3. single error (checked bits so far: 1984) ----
        n_err = 0;
        for (int i = 0; i < 99; i++) begin
            gen_next(gb); step(1'b1, gb, 1'b0);
            if (err_pulse) n_err++;
        end
        gen_next(gb); step(1'b1, ~gb, 1'b0);
        check("single_pulse", 32'(err_pulse), 32'd1);
        check("single_cnt", 32'(err_cnt), 32'd1);
        check("single_locked", 32'(locked), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        check("idle_pulse_drop", 32'(err_pulse), 32'd0);
        for (int i = 0; i < 156; i++) begin
            gen_next(gb); step(1'b1, gb, 1'b0);
            if (err_pulse) n_err++;
        end
        check("single_other_pulses", 32'(n_err), 32'd0);
        check("single_cnt_hold", 32'(err_cnt), 32'd1);

        // ---- 4. loss of sync; 8th error lands on the 64th window bit ----
        step(1'b0, 1'b0, 1'b1);
        check("clr_cnt_idle", 32'(err_cnt), 32'd0);
        n_err = 0;
        for (int i = 0; i < 56; i++) begin
            gen_next(gb); step(1'b1, gb, 1'b0);
            if (err_pulse) n_err++;
        end
        check("pre_burst_clean", 32'(n_err), 32'd0);
        n_lost = 0;
        for (int k = 1; k <= 7; k++) begin
            gen_next(gb); step(1'b1, ~gb, 1'b0);
            if (sync_lost || !locked || !err_pulse) n_lost++;
        end
        check("burst_1_to_7", 32'(n_lost), 32'd0);
        check("burst_cnt_7", 32'(err_cnt), 32'd7);
        gen_next(gb); step(1'b1, ~gb, 1'b0);
        check("loss_pulse", 32'(sync_lost), 32'd1);
        check("loss_err_pulse", 32'(err_pulse), 32'd1);
        check("loss_unlocked", 32'(locked), 32'd0);
        check("loss_err_cnt", 32'(err_cnt), 32'd8);
        gen_next(gb); step(1'b1, gb, 1'b0);
        check("loss_pulse_drop", 32'(sync_lost), 32'd0);
        n_lock = 0;
        for (int i = 0; i < 17; i++) begin
            gen_next(gb); step(1'b1, gb, 1'b0);
            if (locked) n_lock++;
        end
        check("relock_not_early", 32'(n_lock), 32'd0);
        gen_next(gb); step(1'b1, gb, 1'b0);
        check("relock_19", 32'(locked), 32'd1);
        n_err = 0;
        for (int i = 0; i < 2; i++) begin
            gen_next(gb); step(1'b1, gb, 1'b0);
            if (err_pulse) n_err++;
        end
        check("relock_clean", 32'(n_err), 32'd0);

        // ---- 6. 20 errors, one per 16 bits: wrap or saturate ----
        step(1'b0, 1'b0, 1'b1);
        n_err = 0;
        for (int e = 0; e < 20; e++) begin
            for (int i = 0; i < 15; i++) begin
                gen_next(gb); step(1'b1, gb, 1'b0);
                if (err_pulse) n_err++;
            end
            gen_next(gb); step(1'b1, ~gb, 1'b0);
            if (err_pulse) n_err++;
        end
`ifdef PRBS_ERR_SAT_EN
        exp_sat = 32'd15;
`else
        exp_sat = 32'd4;
`endif
        check("spread_pulses", 32'(n_err), 32'd20);
        check("spread_locked", 32'(locked), 32'd1);
        check("spread_err_cnt", 32'(err_cnt), exp_sat);

        // ---- 5b. clr_cnt coinciding with an error ----
        gen_next(gb); step(1'b1, ~gb, 1'b1);
        check("clr_err_pulse", 32'(err_pulse), 32'd1);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        gen_next(gb); step(1'b1, ~gb, 1'b0);
        check("post_clr_cnt", 32'(err_cnt), 32'd1);

        // ---- 1b. reset mid-stream ----
        #1 rst_n = 1'b1;
        #1;
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_cnt", 32'(err_cnt), 32'd0);
        gen_next(gb); step(1'b1, gb, 1'b0);
        gen_next(gb); step(1'b1, gb, 1'b0);
        gen_next(gb); step(1'b1, gb, 1'b0);
        check("mid_rst_hold_lock", 32'(locked), 32'd0);
        check("mid_rst_pulse", 32'(err_pulse), 32'd0);
        rst_n = 1'b0;

        // ---- 5. 200 zeros never lock ----
        n_lock = 0; n_err = 0; n_seed = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (locked) n_lock++;
            if (err_pulse) n_err++;
            if (seed_seen) n_seed++;
        end
        check("zeros_no_lock", 32'(n_lock), 32'd0);
        check("zeros_no_pulse", 32'(n_err), 32'd0);
        check("zeros_no_seed", 32'(n_seed), 32'd0);
        check("zeros_err_cnt", 32'(err_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
